alu_rs: RTL and testbench

- Reservation station for the integer ALU functional unit.
- Sits between dispatch/rename and alu_unit.
- Buffers up to DEPTH ALU micro-ops and captures source operands from the common data bus (CDB) as they are broadcast.
- Each cycle, selects the oldest entry with both operands ready and presents it as next_execute to alu_unit.

---
 rtl/alu_rs.sv | 210 +++++++++++++++++++++
 tb/tb_alu_rs.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers micro-ops, snoops the CDB, and issues the oldest
// ready entry. Optional macro ALU_RS_BYPASS_EN lets a same-cycle CDB broadcast complete readiness.
module alu_rs #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned OP_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [1:0]               disp_m1_sel,
  input  logic [1:0]               disp_m2_sel,
  input  logic                     disp_src1_rdy,
  input  logic                     disp_src2_rdy,
  input  logic [TAG_W-1:0]         disp_src1_tag,
  input  logic [TAG_W-1:0]         disp_src2_tag,
  input  logic [31:0]              disp_src1_val,
  input  logic [31:0]              disp_src2_val,
  input  logic [31:0]              disp_imm,
  input  logic [31:0]              disp_pc,
  input  logic [TAG_W-1:0]         disp_rd_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [31:0]              cdb_val,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OP_W-1:0]          issue_op,
  output logic [1:0]               issue_m1_sel,
  output logic [1:0]               issue_m2_sel,
  output logic [TAG_W-1:0]         issue_rd_tag,
  output logic [31:0]              issue_src1,
  output logic [31:0]              issue_src2,
  output logic [31:0]              issue_imm,
  output logic [31:0]              issue_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [1:0] SelRs = 2'd0;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_s1_rdy;
  logic [DEPTH-1:0] r_s2_rdy;
  logic [OP_W-1:0]  r_op     [DEPTH];
  logic [1:0]       r_m1_sel [DEPTH];
  logic [1:0]       r_m2_sel [DEPTH];
  logic [TAG_W-1:0] r_s1_tag [DEPTH];
  logic [TAG_W-1:0] r_s2_tag [DEPTH];
  logic [TAG_W-1:0] r_rd_tag [DEPTH];
  logic [31:0]      r_s1_val [DEPTH];
  logic [31:0]      r_s2_val [DEPTH];
  logic [31:0]      r_imm    [DEPTH];
  logic [31:0]      r_pc     [DEPTH];
  // r_age[i][j] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] r_age    [DEPTH];

  logic [CntW-1:0]  w_occ;
  logic [IdxW-1:0]  w_free_idx;
  logic             w_disp_fire;
  logic             w_issue_fire;
  logic [DEPTH-1:0] w_s1_hit;
  logic [DEPTH-1:0] w_s2_hit;
  logic [DEPTH-1:0] w_cand;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_valid_d;
  logic             w_d_s1_hit;
  logic             w_d_s2_hit;
  logic             w_d_s1_rdy;
  logic             w_d_s2_rdy;
  logic [31:0]      w_d_s1_val;
  logic [31:0]      w_d_s2_val;

  always_comb begin
    w_occ      = '0;
    w_free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      w_occ = w_occ + CntW'(r_valid[i]);
      if (!r_valid[i]) w_free_idx = IdxW'(i);
    end
  end

  assign occupancy    = w_occ;
  assign disp_ready   = (w_occ < CntW'(DEPTH));
  assign w_disp_fire  = disp_valid && disp_ready;
  assign w_issue_fire = issue_valid && issue_ready;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_s1_hit[i] = cdb_valid && !r_s1_rdy[i] && (r_s1_tag[i] == cdb_tag);
      w_s2_hit[i] = cdb_valid && !r_s2_rdy[i] && (r_s2_tag[i] == cdb_tag);
`ifdef ALU_RS_BYPASS_EN
      w_cand[i] = r_valid[i] && (r_s1_rdy[i] || w_s1_hit[i]) && (r_s2_rdy[i] || w_s2_hit[i]);
`else
      w_cand[i] = r_valid[i] && r_s1_rdy[i] && r_s2_rdy[i];
`endif
    end
  end

  // Oldest-first: an entry wins unless some other candidate is older than it.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_sel[i] = w_cand[i];
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (j != i && w_cand[j] && r_age[i][j]) w_sel[i] = 1'b0;
      end
    end
  end

  assign issue_valid = |w_cand;

  always_comb begin
    issue_op     = '0;
    issue_m1_sel = '0;
    issue_m2_sel = '0;
    issue_rd_tag = '0;
    issue_src1   = '0;
    issue_src2   = '0;
    issue_imm    = '0;
    issue_pc     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_sel[i]) begin
        issue_op     = r_op[i];
        issue_m1_sel = r_m1_sel[i];
        issue_m2_sel = r_m2_sel[i];
        issue_rd_tag = r_rd_tag[i];
        issue_src1   = r_s1_val[i];
        issue_src2   = r_s2_val[i];
        issue_imm    = r_imm[i];
        issue_pc     = r_pc[i];
`ifdef ALU_RS_BYPASS_EN
        if (!r_s1_rdy[i]) issue_src1 = cdb_val;
        if (!r_s2_rdy[i]) issue_src2 = cdb_val;
`endif
      end
    end
  end

  // A broadcast coinciding with dispatch is captured here so it is not lost.
  always_comb begin
    w_d_s1_hit = cdb_valid && (cdb_tag == disp_src1_tag);
    w_d_s2_hit = cdb_valid && (cdb_tag == disp_src2_tag);
    w_d_s1_rdy = disp_src1_rdy || (disp_m1_sel != SelRs) || w_d_s1_hit;
    w_d_s2_rdy = disp_src2_rdy || (disp_m2_sel != SelRs) || w_d_s2_hit;
    w_d_s1_val = (!disp_src1_rdy && w_d_s1_hit) ? cdb_val : disp_src1_val;
    w_d_s2_val = (!disp_src2_rdy && w_d_s2_hit) ? cdb_val : disp_src2_val;
  end

  always_comb begin
    w_valid_d = r_valid;
    if (w_issue_fire) w_valid_d = w_valid_d & ~w_sel;
    if (w_disp_fire)  w_valid_d[w_free_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= '0;
      r_s1_rdy <= '0;
      r_s2_rdy <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_op[i]     <= '0;
        r_m1_sel[i] <= '0;
        r_m2_sel[i] <= '0;
        r_s1_tag[i] <= '0;
        r_s2_tag[i] <= '0;
        r_rd_tag[i] <= '0;
        r_s1_val[i] <= '0;
        r_s2_val[i] <= '0;
        r_imm[i]    <= '0;
        r_pc[i]     <= '0;
        r_age[i]    <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_age[i] <= '0;
    end else begin
      r_valid <= w_valid_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (r_valid[i] && w_s1_hit[i]) begin
          r_s1_rdy[i] <= 1'b1;
          r_s1_val[i] <= cdb_val;
        end
        if (r_valid[i] && w_s2_hit[i]) begin
          r_s2_rdy[i] <= 1'b1;
          r_s2_val[i] <= cdb_val;
        end
      end
      if (w_disp_fire) begin
        r_op[w_free_idx]     <= disp_op;
        r_m1_sel[w_free_idx] <= disp_m1_sel;
        r_m2_sel[w_free_idx] <= disp_m2_sel;
        r_s1_tag[w_free_idx] <= disp_src1_tag;
        r_s2_tag[w_free_idx] <= disp_src2_tag;
        r_rd_tag[w_free_idx] <= disp_rd_tag;
        r_s1_rdy[w_free_idx] <= w_d_s1_rdy;
        r_s2_rdy[w_free_idx] <= w_d_s2_rdy;
        r_s1_val[w_free_idx] <= w_d_s1_val;
        r_s2_val[w_free_idx] <= w_d_s2_val;
        r_imm[w_free_idx]    <= disp_imm;
        r_pc[w_free_idx]     <= disp_pc;
        for (int r = 0; r < int'(DEPTH); r++) r_age[r][w_free_idx] <= 1'b0;
        r_age[w_free_idx] <= r_valid;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: expected issues are queued at dispatch and checked at issue fire.
module tb_alu_rs;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_op;
  logic [1:0]  disp_m1_sel;
  logic [1:0]  disp_m2_sel;
  logic        disp_src1_rdy;
  logic        disp_src2_rdy;
  logic [4:0]  disp_src1_tag;
  logic [4:0]  disp_src2_tag;
  logic [31:0] disp_src1_val;
  logic [31:0] disp_src2_val;
  logic [31:0] disp_imm;
  logic [31:0] disp_pc;
  logic [4:0]  disp_rd_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [1:0]  issue_m1_sel;
  logic [1:0]  issue_m2_sel;
  logic [4:0]  issue_rd_tag;
  logic [31:0] issue_src1;
  logic [31:0] issue_src2;
  logic [31:0] issue_imm;
  logic [31:0] issue_pc;
  logic [2:0]  occupancy;

  alu_rs #(.DEPTH(4), .TAG_W(5), .OP_W(4)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_op       (disp_op),
    .disp_m1_sel   (disp_m1_sel),
    .disp_m2_sel   (disp_m2_sel),
    .disp_src1_rdy (disp_src1_rdy),
    .disp_src2_rdy (disp_src2_rdy),
    .disp_src1_tag (disp_src1_tag),
    .disp_src2_tag (disp_src2_tag),
    .disp_src1_val (disp_src1_val),
    .disp_src2_val (disp_src2_val),
    .disp_imm      (disp_imm),
    .disp_pc       (disp_pc),
    .disp_rd_tag   (disp_rd_tag),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_val       (cdb_val),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_m1_sel  (issue_m1_sel),
    .issue_m2_sel  (issue_m2_sel),
    .issue_rd_tag  (issue_rd_tag),
    .issue_src1    (issue_src1),
    .issue_src2    (issue_src2),
    .issue_imm     (issue_imm),
    .issue_pc      (issue_pc),
    .occupancy     (occupancy)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        c1;
    logic        c2;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] imm_of(input logic [4:0] rd);
    return 32'd100 + 32'(rd);
  endfunction

  function automatic logic [31:0] pc_of(input logic [4:0] rd);
    return 32'h1000 + (32'(rd) << 2);
  endfunction

  task automatic push_exp(input logic [4:0] rd, input logic [3:0] op, input logic [31:0] s1,
                          input logic [31:0] s2, input logic c1, input logic c2);
    exp_t e;
    e.rd = rd; e.op = op; e.s1 = s1; e.s2 = s2; e.c1 = c1; e.c2 = c2;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the dispatch edge.
  task automatic dispatch(input logic [3:0] op, input logic [1:0] m1, input logic [1:0] m2,
                          input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [4:0] t2, input logic [31:0] v2,
                          input logic [4:0] rd);
    disp_valid    = 1'b1;
    disp_op       = op;
    disp_m1_sel   = m1;
    disp_m2_sel   = m2;
    disp_src1_rdy = r1;
    disp_src1_tag = t1;
    disp_src1_val = v1;
    disp_src2_rdy = r2;
    disp_src2_tag = t2;
    disp_src2_val = v2;
    disp_rd_tag   = rd;
    disp_imm      = imm_of(rd);
    disp_pc       = pc_of(rd);
    @(posedge clk);
    #1;
    disp_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && occupancy != 3'd0; k++) step();
    @(negedge clk);
    check(tag, 32'(occupancy), 32'd0);
    step();
  endtask

  always @(negedge clk) begin
    if (rst && !flush && issue_valid && issue_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_issue", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("issue_rd_tag", 32'(issue_rd_tag), 32'(e.rd));
        check("issue_op", 32'(issue_op), 32'(e.op));
        check("issue_imm", issue_imm, imm_of(e.rd));
        check("issue_pc", issue_pc, pc_of(e.rd));
        if (e.c1) check("issue_src1", issue_src1, e.s1);
        if (e.c2) check("issue_src2", issue_src2, e.s2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
    disp_op = '0; disp_m1_sel = '0; disp_m2_sel = '0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_src1_tag = '0; disp_src2_tag = '0;
    disp_src1_val = '0; disp_src2_val = '0; disp_imm = '0; disp_pc = '0; disp_rd_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;

    // Reset state
    #12;
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_issue_src1", issue_src1, 32'd0);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("idle_issue_valid", 32'(issue_valid), 32'd0);
    step();

    // Simple ADD, both operands ready
    issue_ready = 1'b1;
    push_exp(5'd1, 4'd0, 32'd5, 32'd7, 1'b1, 1'b1);
    dispatch(4'd0, 2'd0, 2'd0, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7, 5'd1);
    @(negedge clk);
    check("add_issue_valid", 32'(issue_valid), 32'd1);
    check("add_occupancy", 32'(occupancy), 32'd1);
    step();
    @(negedge clk);
    check("add_freed_occ", 32'(occupancy), 32'd0);
    check("add_freed_valid", 32'(issue_valid), 32'd0);
    step();

    // Wait on tag 3, broadcast two cycles after dispatch
    push_exp(5'd2, 4'd3, 32'hDEAD, 32'd2, 1'b1, 1'b1);
    dispatch(4'd3, 2'd0, 2'd0, 1'b0, 5'd3, 32'd0, 1'b1, 5'd0, 32'd2, 5'd2);
    @(negedge clk);
    check("wait_not_ready", 32'(issue_valid), 32'd0);
    step();
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_val = 32'hDEAD;
    @(negedge clk);
`ifdef ALU_RS_BYPASS_EN
    check("wake_same_cycle", 32'(issue_valid), 32'd1);
`else
    check("wake_same_cycle", 32'(issue_valid), 32'd0);
`endif
    step();
    cdb_valid = 1'b0;
    @(negedge clk);
`ifdef ALU_RS_BYPASS_EN
    check("wake_next_cycle", 32'(issue_valid), 32'd0);
`else
    check("wake_next_cycle", 32'(issue_valid), 32'd1);
`endif
    step();
    wait_idle("wake_idle");

    // Fill, hold, then drain in age order with entry reuse
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_exp(5'(10 + k), 4'(k), 32'(k * 11), 32'(k * 13), 1'b1, 1'b1);
      dispatch(4'(k), 2'd0, 2'd0, 1'b1, 5'd0, 32'(k * 11), 1'b1, 5'd0, 32'(k * 13), 5'(10 + k));
    end
    @(negedge clk);
    check("full_disp_ready", 32'(disp_ready), 32'd0);
    check("full_occupancy", 32'(occupancy), 32'd4);
    dispatch(4'd9, 2'd0, 2'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1, 5'd30);
    @(negedge clk);
    check("full_ignored", 32'(occupancy), 32'd4);
    issue_ready = 1'b1;
    step();
    @(negedge clk);
    check("drain_occ3", 32'(occupancy), 32'd3);
    push_exp(5'd14, 4'd5, 32'd77, 32'd88, 1'b1, 1'b1);
    dispatch(4'd5, 2'd0, 2'd0, 1'b1, 5'd0, 32'd77, 1'b1, 5'd0, 32'd88, 5'd14);
    @(negedge clk);
    check("disp_and_issue_occ", 32'(occupancy), 32'd3);
    step();
    wait_idle("drain_idle");

    // CDB broadcast coinciding with dispatch
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_val = 32'h1234;
    push_exp(5'd20, 4'd1, 32'd4, 32'h1234, 1'b1, 1'b1);
    dispatch(4'd1, 2'd0, 2'd0, 1'b1, 5'd0, 32'd4, 1'b0, 5'd9, 32'd0, 5'd20);
    cdb_valid = 1'b0;
    @(negedge clk);
    check("capture_issue_valid", 32'(issue_valid), 32'd1);
    step();
    wait_idle("capture_idle");

    // Unused sources (pc / imm) are ready at dispatch
    push_exp(5'd21, 4'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    dispatch(4'd2, 2'd1, 2'd1, 1'b0, 5'd7, 32'd0, 1'b0, 5'd8, 32'd0, 5'd21);
    @(negedge clk);
    check("unused_src_issue", 32'(issue_valid), 32'd1);
    step();
    wait_idle("unused_idle");

    // Flush with concurrent dispatch
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      dispatch(4'd0, 2'd0, 2'd0, 1'b0, 5'd4, 32'd0, 1'b1, 5'd0, 32'd0, 5'(22 + k));
    flush = 1'b1;
    dispatch(4'd0, 2'd0, 2'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2, 5'd26);
    flush = 1'b0;
    @(negedge clk);
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_issue_valid", 32'(issue_valid), 32'd0);
    step();

    // Async reset mid-cycle with three live entries
    for (int k = 0; k < 3; k++)
      dispatch(4'd0, 2'd0, 2'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1, 5'(27 + k));
    @(negedge clk);
    check("pre_rst_occ", 32'(occupancy), 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_occ", 32'(occupancy), 32'd0);
    check("async_rst_issue_valid", 32'(issue_valid), 32'd0);
    check("async_rst_disp_ready", 32'(disp_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
